// File: rtl/tetris_game_ctrl.sv
// tetris_game_ctrl: sequences spawn/move/lock/line-clear and arbitrates player and gravity requests onto one check port.
// Optional TETRIS_SPEEDUP_EN adds a 0..3 level that halves the gravity period per step.
module tetris_game_ctrl #(
  parameter int GRAVITY_DIV = 25_000_000,
  parameter int CNT_W       = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_cw,
  input  logic        btn_ccw,
  input  logic        btn_drop,
  output logic        board_clr,
  output logic        spawn_req,
  input  logic        spawn_done,
  input  logic        spawn_ok,
  output logic        chk_valid,
  output logic [2:0]  chk_op,
  input  logic        chk_ready,
  input  logic        chk_done,
  input  logic        chk_ok,
  output logic        commit,
  output logic        lock,
  output logic [4:0]  row_idx,
  input  logic        row_full,
  output logic        shift_row,
  output logic [15:0] lines_cleared,
  output logic        game_over,
  output logic [2:0]  state
);
  typedef enum logic [2:0] {IDLE, SPAWN, ACTIVE, CHECK, COMMIT, LOCK, CLEAR, OVER} state_t;
  localparam logic [2:0] OP_DOWN = 3'd0, OP_LEFT = 3'd1, OP_RIGHT = 3'd2, OP_CW = 3'd3, OP_CCW = 3'd4;

  state_t          state_q;
  logic            grav_q, drop_q, cw_q, ccw_q, left_q, right_q, dropping_q, acc_q;
  logic            board_clr_q, spawn_req_q, chk_valid_q, commit_q, lock_q, game_over_q;
  logic [2:0]      op_q;
  logic [4:0]      row_q;
  logic [15:0]     lines_q;
  logic [CNT_W-1:0] cnt_q, period;
  logic            live, running, tick, any_flag;
  logic [2:0]      pick_op;

`ifdef TETRIS_SPEEDUP_EN
  logic [1:0] level_q;
  logic [3:0] tens_q;
  logic       lvl_up_q;
  assign period = CNT_W'(GRAVITY_DIV) >> level_q;
`else
  assign period = CNT_W'(GRAVITY_DIV);
`endif

  assign live     = state_q != IDLE && state_q != OVER;
  assign running  = state_q == ACTIVE || state_q == CHECK || state_q == COMMIT;
  assign tick     = running && cnt_q == period - 1'b1;
  assign any_flag = grav_q | drop_q | cw_q | ccw_q | left_q | right_q;
  assign pick_op  = (grav_q | drop_q) ? OP_DOWN : cw_q ? OP_CW : ccw_q ? OP_CCW : left_q ? OP_LEFT : OP_RIGHT;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      {grav_q, drop_q, cw_q, ccw_q, left_q, right_q, dropping_q, acc_q} <= '0;
      {board_clr_q, spawn_req_q, chk_valid_q, commit_q, lock_q, game_over_q} <= '0;
      op_q    <= '0;
      row_q   <= '0;
      lines_q <= '0;
      cnt_q   <= '0;
`ifdef TETRIS_SPEEDUP_EN
      level_q  <= '0;
      tens_q   <= '0;
      lvl_up_q <= 1'b0;
`endif
    end else begin
      if (live) begin
        grav_q  <= grav_q | tick;
        drop_q  <= drop_q | btn_drop;
        cw_q    <= cw_q | btn_cw;
        ccw_q   <= ccw_q | btn_ccw;
        left_q  <= left_q | btn_left;
        right_q <= right_q | btn_right;
      end
      cnt_q <= (state_q == SPAWN || tick) ? '0 : running ? cnt_q + 1'b1 : cnt_q;
      case (state_q)
        IDLE, OVER: begin
          if (board_clr_q) begin
            board_clr_q <= 1'b0;
            game_over_q <= 1'b0;
            spawn_req_q <= 1'b1;
            state_q     <= SPAWN;
          end else if (start) begin
            board_clr_q <= 1'b1;
            lines_q     <= '0;
            {grav_q, drop_q, cw_q, ccw_q, left_q, right_q, dropping_q} <= '0;
`ifdef TETRIS_SPEEDUP_EN
            level_q  <= '0;
            tens_q   <= '0;
            lvl_up_q <= 1'b0;
`endif
          end
        end
        SPAWN: if (spawn_done) begin
          spawn_req_q <= 1'b0;
          game_over_q <= !spawn_ok;
          state_q     <= spawn_ok ? ACTIVE : OVER;
        end
        ACTIVE: if (any_flag) begin
          op_q        <= pick_op;
          dropping_q  <= !grav_q && drop_q;
          chk_valid_q <= 1'b1;
          acc_q       <= 1'b0;
          state_q     <= CHECK;
          if (grav_q) grav_q <= 1'b0;
          else if (drop_q) drop_q <= 1'b0;
          else if (cw_q) cw_q <= 1'b0;
          else if (ccw_q) ccw_q <= 1'b0;
          else if (left_q) left_q <= 1'b0;
          else right_q <= 1'b0;
        end
        // a result is only taken once the request has been accepted on an earlier edge
        CHECK: if (!acc_q) begin
          if (chk_ready) begin
            acc_q       <= 1'b1;
            chk_valid_q <= 1'b0;
          end
        end else if (chk_done) begin
          acc_q <= 1'b0;
          if (chk_ok) begin
            commit_q <= 1'b1;
            state_q  <= COMMIT;
          end else if (op_q == OP_DOWN) begin
            lock_q     <= 1'b1;
            dropping_q <= 1'b0;
            state_q    <= LOCK;
          end else begin
            state_q <= ACTIVE;
          end
        end
        COMMIT: begin
          commit_q    <= 1'b0;
          chk_valid_q <= dropping_q;
          state_q     <= dropping_q ? CHECK : ACTIVE;
        end
        LOCK: begin
          lock_q  <= 1'b0;
          {grav_q, drop_q, cw_q, ccw_q, left_q, right_q} <= '0;
          row_q   <= 5'd19;
          state_q <= CLEAR;
        end
        CLEAR: if (row_full) begin
          lines_q <= lines_q + 16'd1;
`ifdef TETRIS_SPEEDUP_EN
          tens_q <= tens_q == 4'd9 ? 4'd0 : tens_q + 4'd1;
          if (tens_q == 4'd9) lvl_up_q <= 1'b1;
`endif
        end else if (row_q == 5'd0) begin
          spawn_req_q <= 1'b1;
          state_q     <= SPAWN;
`ifdef TETRIS_SPEEDUP_EN
          lvl_up_q <= 1'b0;
          if (lvl_up_q && level_q != 2'd3) level_q <= level_q + 2'd1;
`endif
        end else begin
          row_q <= row_q - 5'd1;
        end
      endcase
    end
  end

  assign board_clr     = board_clr_q;
  assign spawn_req     = spawn_req_q;
  assign chk_valid     = chk_valid_q;
  assign chk_op        = op_q;
  assign commit        = commit_q;
  assign lock          = lock_q;
  assign row_idx       = row_q;
  assign shift_row     = state_q == CLEAR && row_full;
  assign lines_cleared = lines_q;
  assign game_over     = game_over_q;
  assign state         = state_q;
endmodule
